alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ALU datapath between NREQ requesters (e.g. command decoder, address/refresh calculators in the DDR3 controller).
- Round-robin arbitration, registered operand launch into the ALU, result/flag capture after a fixed settle time, valid/ready response handshake.
- Sits between requester logic and the combinational ALU instance; owns all ALU input drive.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of resp_id; must satisfy 2**IDW >= NREQ.
- ALU_LAT, 1, clock cycles allowed for ALU settle after launch (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  16*NREQ  operand a; requester i at bits [16i+15:16i].
- req_b  input  16*NREQ  operand b, same packing.
- req_opcode  input  3*NREQ  opcode, same packing.
- req_mode  input  NREQ  0 = arithmetic, 1 = logic.
- alu_a  output  16  registered operand a to ALU.
- alu_b  output  16  registered operand b to ALU.
- alu_opcode  output  3  registered opcode to ALU.
- alu_mode  output  1  registered mode to ALU.
- alu_out  input  32  ALU result.
- alu_flags  input  5  ALU flags {za,zb,eq,gt,lt}.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  IDW  index of the requester that owns the response.
- resp_result  output  32  captured alu_out.
- resp_flags  output  5  captured alu_flags.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0; state = IDLE.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Settle counter = 0.
- Reset asserted mid-operation aborts the operation: no response is produced and no operand is retained.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first valid index searching upward from last_grant+1, modulo NREQ.
  - req_ready[winner] is driven combinationally high in IDLE only.
  - Handshake completes on that clock edge. At the edge:
    - alu_* are loaded from the winner's slice;
    - resp_id and last_grant are loaded with the winner;
    - counter = ALU_LAT-1;
    - state goes to WAIT.
  - With no valid request, stay in IDLE.
- WAIT:
  - While counter != 0, decrement.
  - When counter == 0, capture alu_out into resp_result and alu_flags into resp_flags, set resp_valid, go to RESP.
- RESP:
  - resp_valid held high; resp_id, resp_result and resp_flags held stable until the edge where resp_ready is high.
  - On that edge, clear resp_valid and go to IDLE.
  - No new request is accepted in the same cycle (minimum 3 cycles per op when ALU_LAT = 1).
- alu_* outputs hold their last value outside a launch; they are never changed in WAIT or RESP.
- Latency: request accepted at edge N; resp_valid high from edge N+ALU_LAT onward.
- Fairness: a continuously requesting client waits at most NREQ-1 operations.
- req_ready is never asserted in WAIT or RESP, or while rst is high.
- Requesters hold req_* stable while req_valid is high and not yet accepted. The arbiter does not check this.
- A requester dropping req_valid before its grant is legal; that requester is simply skipped.

Decomposition:
- Shared package alu_pkg:
  - localparams OPW=3, DW=16, RW=32, FW=5;
  - flag bit indices ZA=4, ZB=3, EQ=2, GT=1, LT=0;
  - FSM state encodings.
- One sub-module, rr_arbiter (NREQ input; inputs req vector and last_grant; outputs one-hot grant and encoded index; purely combinational).
- FSM, operand registers and response registers live in alu_arbiter.

Test Plan:
Bench ALU stub: outALU = mode ? (a & b) : (a + b); flags computed from a and b.
- Single request: reset, req_valid=2'b01, a=16'h0003, b=16'h0004, mode=0, ALU_LAT=1 -> req_ready=01 for one cycle; resp_valid next edge; result=32'h00000007, flags eq=0 lt=1, resp_id=0.
- Round-robin: both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 over 4 ops; resp_id sequence 0,1,0,1.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, result and id stable; req_ready stays 0; on resp_ready=1 the FSM returns to IDLE next cycle.
- Logic op and zero flag: a=16'h0000, b=16'hF0F0, mode=1 -> result=32'h00000000; flags za=1 zb=0 gt=0 lt=1.
- ALU_LAT=4: accept at edge N -> capture at edge N+4; alu_* constant over cycles N+1..N+4.
- Reset mid-WAIT: assert rst asynchronously between edges -> all outputs 0 immediately; after release, requester 0 is granted first; no stale response.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and FSM encoding for the ALU arbiter slice.
package alu_pkg;

  localparam int OPW = 3;
  localparam int DW  = 16;
  localparam int RW  = 32;
  localparam int FW  = 5;

  localparam int ZA = 4;
  localparam int ZB = 3;
  localparam int EQ = 2;
  localparam int GT = 1;
  localparam int LT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first asserted request above last_grant,
// wrapping to the lowest index when nothing above it is requesting.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [NREQ-1:0] hi_grant, lo_grant;
  logic [IDW-1:0]  hi_idx, lo_idx;
  logic            hi_found, lo_found;

  // Two unrolled scans replace the modulo walk: indices above last_grant win first.
  always_comb begin
    hi_grant = '0;
    lo_grant = '0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (IDW'(i) > last_grant) begin
          if (!hi_found) begin
            hi_found    = 1'b1;
            hi_grant[i] = 1'b1;
            hi_idx      = IDW'(i);
          end
        end else if (!lo_found) begin
          lo_found    = 1'b1;
          lo_grant[i] = 1'b1;
          lo_idx      = IDW'(i);
        end
      end
    end
    grant = hi_found ? hi_grant : lo_grant;
    idx   = hi_found ? hi_idx   : lo_idx;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered operand launch, capture after ALU_LAT cycles, valid/ready response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [16*NREQ-1:0]  req_a,
  input  logic [16*NREQ-1:0]  req_b,
  input  logic [3*NREQ-1:0]   req_opcode,
  input  logic [NREQ-1:0]     req_mode,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [2:0]          alu_opcode,
  output logic                alu_mode,
  input  logic [31:0]         alu_out,
  input  logic [4:0]          alu_flags,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [31:0]         resp_result,
  output logic [4:0]          resp_flags,
  output logic                busy
);

  state_t          state, state_next;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  last_grant;
  logic [3:0]      cnt;
  logic [DW-1:0]   sel_a, sel_b;
  logic [OPW-1:0]  sel_op;
  logic            sel_mode;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .idx       (win_idx)
  );

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = '0;
    sel_mode = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[DW*i +: DW];
        sel_b    = req_b[DW*i +: DW];
        sel_op   = req_opcode[OPW*i +: OPW];
        sel_mode = req_mode[i];
      end
    end
  end

  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req_valid) state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= IDW'(NREQ - 1);
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      alu_mode    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_opcode <= sel_op;
            alu_mode   <= sel_mode;
            resp_id    <= win_idx;
            last_grant <= win_idx;
            cnt        <= 4'(ALU_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_result <= alu_out;
            resp_flags  <= alu_flags;
            resp_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for grant/result/flags plus
// hand-written backpressure, round-robin, long-latency and reset-abort sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_opcode;
  logic [1:0]  req_mode;
  logic        resp_ready;

  logic [1:0]  req_ready1, req_ready4;
  logic [15:0] alu_a1, alu_b1, alu_a4, alu_b4;
  logic [2:0]  alu_op1, alu_op4;
  logic        alu_mode1, alu_mode4;
  logic [31:0] alu_out1, alu_out4;
  logic [4:0]  alu_flags1, alu_flags4;
  logic        resp_valid1, resp_valid4;
  logic        resp_id1, resp_id4;
  logic [31:0] resp_result1, resp_result4;
  logic [4:0]  resp_flags1, resp_flags4;
  logic        busy1, busy4;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2), .IDW(1), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_mode(req_mode),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opcode(alu_op1), .alu_mode(alu_mode1),
    .alu_out(alu_out1), .alu_flags(alu_flags1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_id(resp_id1), .resp_result(resp_result1),
    .resp_flags(resp_flags1), .busy(busy1)
  );

  alu_arbiter #(.NREQ(2), .IDW(1), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_mode(req_mode),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_op4), .alu_mode(alu_mode4),
    .alu_out(alu_out4), .alu_flags(alu_flags4), .resp_valid(resp_valid4),
    .resp_ready(resp_ready), .resp_id(resp_id4), .resp_result(resp_result4),
    .resp_flags(resp_flags4), .busy(busy4)
  );

  // ALU stubs: mode 1 = AND, mode 0 = ADD; flags {za,zb,eq,gt,lt}
  always_comb begin
    alu_out1   = alu_mode1 ? {16'h0, alu_a1 & alu_b1} : 32'(alu_a1) + 32'(alu_b1);
    alu_flags1 = {alu_a1 == 16'h0, alu_b1 == 16'h0, alu_a1 == alu_b1, alu_a1 > alu_b1, alu_a1 < alu_b1};
    alu_out4   = alu_mode4 ? {16'h0, alu_a4 & alu_b4} : 32'(alu_a4) + 32'(alu_b4);
    alu_flags4 = {alu_a4 == 16'h0, alu_b4 == 16'h0, alu_a4 == alu_b4, alu_a4 > alu_b4, alu_a4 < alu_b4};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] a0, b0;
    logic        m0;
    logic [15:0] a1, b1;
    logic        m1;
    logic        eid;
    logic [31:0] eres;
    logic [4:0]  eflg;
  } vec_t;

  vec_t vt[7];
  int   seen;
  logic exp_rr[4];

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    req_mode   = '0;
    resp_ready = 1'b0;

    vt[0] = '{2'b01, 16'h0003, 16'h0004, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h00000007, 5'b00001};
    vt[1] = '{2'b11, 16'h0003, 16'h0004, 1'b0, 16'h0000, 16'hF0F0, 1'b1, 1'b1, 32'h00000000, 5'b10001};
    vt[2] = '{2'b11, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hF0F0, 1'b1, 1'b0, 32'h00010000, 5'b00010};
    vt[3] = '{2'b11, 16'hFFFF, 16'h0001, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1, 32'h00002468, 5'b00100};
    vt[4] = '{2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 32'h00000000, 5'b11100};
    vt[5] = '{2'b01, 16'h5A5A, 16'hFF00, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h00005A00, 5'b00001};
    vt[6] = '{2'b11, 16'h8000, 16'h7FFF, 1'b0, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 32'h000000F0, 5'b00010};

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_alu_a", 32'(alu_a1), 32'h0);
    chk("rst_req_ready", 32'(req_ready1), 32'h0);
    rst = 1'b0;

    // Vector table, ALU_LAT=1, consumer always ready
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid  = vt[i].rv;
      req_a      = {vt[i].a1, vt[i].a0};
      req_b      = {vt[i].b1, vt[i].b0};
      req_mode   = {vt[i].m1, vt[i].m0};
      resp_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(req_ready1), vt[i].eid ? 32'h2 : 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      chk($sformatf("v%0d_busy", i), 32'(busy1), 32'h1);
      chk($sformatf("v%0d_alu_a", i), 32'(alu_a1), 32'(vt[i].eid ? vt[i].a1 : vt[i].a0));
      chk($sformatf("v%0d_ready_wait", i), 32'(req_ready1), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid1), 32'h1);
      chk($sformatf("v%0d_id", i), 32'(resp_id1), 32'(vt[i].eid));
      chk($sformatf("v%0d_result", i), resp_result1, vt[i].eres);
      chk($sformatf("v%0d_flags", i), 32'(resp_flags1), 32'(vt[i].eflg));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done", i), 32'({resp_valid1, busy1}), 32'h0);
    end

    // Backpressure: 5 cycles held in RESP with both requesters pending
    do_reset();
    @(negedge clk);
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h0007};
    req_b     = {16'h0000, 16'h0009};
    req_mode  = 2'b00;
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), 32'(resp_valid1), 32'h1);
      chk($sformatf("bp%0d_result", k), resp_result1, 32'h00000010);
      chk($sformatf("bp%0d_id", k), 32'(resp_id1), 32'h0);
      chk($sformatf("bp%0d_ready", k), 32'(req_ready1), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    chk("bp_release_valid", 32'(resp_valid1), 32'h0);
    chk("bp_release_busy", 32'(busy1), 32'h0);
    req_valid = 2'b11;
    #1;
    chk("bp_next_grant", 32'(req_ready1), 32'h2);
    req_valid = 2'b00;

    // Round-robin with both requesters continuously valid
    do_reset();
    exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      @(negedge clk);
      if (resp_valid1) begin
        chk($sformatf("rr%0d_id", seen), 32'(resp_id1), 32'(exp_rr[seen]));
        seen++;
      end
    end
    chk("rr_count", 32'(seen), 32'd4);
    req_valid = '0;

    // ALU_LAT=4: capture four edges after accept, operands held meanwhile
    do_reset();
    req_valid = 2'b01;
    req_a     = {16'h0000, 16'h0010};
    req_b     = {16'h0000, 16'h0020};
    req_mode  = 2'b00;
    #1;
    chk("lat4_grant", 32'(req_ready4), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    req_a     = {16'h0000, 16'hAAAA};
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lat4_e%0d_alu", k), {alu_a4, alu_b4}, 32'h00100020);
      chk($sformatf("lat4_e%0d_valid", k), 32'(resp_valid4), (k == 4) ? 32'h1 : 32'h0);
    end
    chk("lat4_result", resp_result4, 32'h00000030);

    // Asynchronous reset during WAIT aborts the operation
    do_reset();
    req_valid = 2'b10;
    req_a     = {16'h1111, 16'h0002};
    req_b     = {16'h2222, 16'h0003};
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy4), 32'h0);
    chk("arst_alu_a", 32'(alu_a4), 32'h0);
    chk("arst_resp", 32'({resp_valid4, resp_id4}), 32'h0);
    chk("arst_ready", 32'(req_ready4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_first_grant", 32'(req_ready4), 32'h1);
    chk("arst_no_stale", 32'(resp_valid4), 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_new_valid", 32'(resp_valid4), 32'h1);
    chk("arst_new_id", 32'(resp_id4), 32'h0);
    chk("arst_new_result", resp_result4, 32'h00000005);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
